// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and status bundle between the control decoder
// and the program-counter sequencer.
//   master : drives start/halt/stall/branch controls and LUT writes,
//            observes prog_counter, done and lut_miss.
//   slave  : the sequencer itself (pc_sequencer).
interface pc_sequencer_if #(
  parameter int D         = 12,
  parameter int IMM_W     = 4,
  parameter int LUT_DEPTH = 16
);
  localparam int LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

  logic              start;
  logic              halt;
  logic              stall;
  logic              branch_en;
  logic              imm_or_lut;
  logic [IMM_W-1:0]  ctrl;
  logic              lut_wr_en;
  logic [LUT_AW-1:0] lut_wr_addr;
  logic [D-1:0]      lut_wr_data;
  logic              lut_wr_abs;
  logic [D-1:0]      prog_counter;
  logic              done;
  logic              lut_miss;

  modport master (
    output start, halt, stall, branch_en, imm_or_lut, ctrl,
           lut_wr_en, lut_wr_addr, lut_wr_data, lut_wr_abs,
    input  prog_counter, done, lut_miss
  );

  modport slave (
    input  start, halt, stall, branch_en, imm_or_lut, ctrl,
           lut_wr_en, lut_wr_addr, lut_wr_data, lut_wr_abs,
    output prog_counter, done, lut_miss
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter. Branch targets come either from a
// sign-extended immediate (PC-relative) or from a run-time writable LUT whose
// entries are relative offsets or absolute targets. Sequencing is
// IDLE -> RUN -> HALTED with stall and a one-cycle miss pulse for branches
// through unprogrammed LUT entries.
// Ports:
//   Clk   : system clock, all state on the rising edge
//   Reset : synchronous, active-low reset
//   bus   : pc_sequencer_if.slave (controls, LUT write port, PC/status out)
module pc_sequencer #(
  parameter int             D          = 12,
  parameter int             IMM_W      = 4,
  parameter int             LUT_DEPTH  = 16,
  parameter logic [D-1:0]   START_ADDR = '0
) (
  input  logic Clk,
  input  logic Reset,
  pc_sequencer_if.slave bus
);
  localparam int LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t       state;
  logic [D-1:0] pc;
  logic         done;
  logic         lut_miss;

  logic [D-1:0] lut_data  [LUT_DEPTH];
  logic         lut_abs   [LUT_DEPTH];
  logic         lut_valid [LUT_DEPTH];

  logic [LUT_AW-1:0] lut_idx;
  logic              lut_hit;
  logic [D-1:0]      lut_target;
  logic [D-1:0]      imm_sext;

  // LUT read is purely from registered contents, so a write to the same
  // index in this cycle is only seen from the next cycle on.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    lut_idx    = bus.ctrl[LUT_AW-1:0];
    lut_hit    = 1'b0;
    lut_target = pc + D'(1);
    imm_sext   = {{(D-IMM_W){bus.ctrl[IMM_W-1]}}, bus.ctrl};
    if (int'(bus.ctrl) < LUT_DEPTH && lut_valid[lut_idx]) begin
      lut_hit    = 1'b1;
      lut_target = lut_abs[lut_idx] ? lut_data[lut_idx]
                                    : pc + lut_data[lut_idx];
    end
  end

  // NOTE: LUT data and abs flags are storage only and are not reset; the
  // valid bits alone decide whether an entry may be used.
  always_ff @(posedge Clk) begin
    if (bus.lut_wr_en && int'(bus.lut_wr_addr) < LUT_DEPTH) begin
      lut_data[bus.lut_wr_addr] <= bus.lut_wr_data;
      lut_abs[bus.lut_wr_addr]  <= bus.lut_wr_abs;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_valid[i] <= 1'b0;
    end else if (bus.lut_wr_en && int'(bus.lut_wr_addr) < LUT_DEPTH) begin
      lut_valid[bus.lut_wr_addr] <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values sampled at the same clock edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      pc       <= START_ADDR;
      done     <= 1'b0;
      lut_miss <= 1'b0;
    end else begin
      lut_miss <= 1'b0;
      unique case (state)
        IDLE: begin
          pc <= START_ADDR;
          if (bus.start) state <= RUN;
        end
        RUN: begin
          // A stall freezes everything, including halt and branch requests.
          if (!bus.stall) begin
            if (bus.halt) begin
              state <= HALTED;
              done  <= 1'b1;
            end else if (bus.branch_en && !bus.imm_or_lut) begin
              pc <= pc + imm_sext;
            end else if (bus.branch_en) begin
              pc       <= lut_target;
              lut_miss <= !lut_hit;
            end else begin
              pc <= pc + D'(1);
            end
          end
        end
        HALTED: begin
          if (bus.start) begin
            state <= RUN;
            pc    <= START_ADDR;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.prog_counter = pc;
  assign bus.done         = done;
  assign bus.lut_miss     = lut_miss;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. Each driven cycle pushes
// its expected {PC, done, lut_miss} and the observed values are captured 1 ns
// after the following rising edge; each scenario task drains and compares.
module tb_pc_sequencer;
  localparam int D         = 12;
  localparam int IMM_W     = 4;
  localparam int LUT_DEPTH = 16;

  typedef struct packed {
    logic [D-1:0] pc;
    logic         done;
    logic         miss;
  } obs_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  pc_sequencer_if #(.D(D), .IMM_W(IMM_W), .LUT_DEPTH(LUT_DEPTH)) bus ();

  pc_sequencer #(.D(D), .IMM_W(IMM_W), .LUT_DEPTH(LUT_DEPTH),
                 .START_ADDR(12'h000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic obs_t mk(input logic [D-1:0] pc, input logic d,
                              input logic m);
    obs_t r;
    r.pc   = pc;
    r.done = d;
    r.miss = m;
    return r;
  endfunction

  // One clock of stimulus; the expectation is queued as the stimulus is driven.
  task automatic cyc(input logic rst_v, input logic st, input logic hl,
                     input logic sl, input logic br, input logic iol,
                     input logic [IMM_W-1:0] c, input obs_t e);
    obs_t o;
    Reset          = rst_v;
    bus.start      = st;
    bus.halt       = hl;
    bus.stall      = sl;
    bus.branch_en  = br;
    bus.imm_or_lut = iol;
    bus.ctrl       = c;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    o.pc   = bus.prog_counter;
    o.done = bus.done;
    o.miss = bus.lut_miss;
    obs_q.push_back(o);
    bus.lut_wr_en = 1'b0;
  endtask

  // Arms a one-shot LUT write for the next cyc() call.
  task automatic lut_wr(input logic [3:0] addr, input logic [D-1:0] data,
                        input logic abs_v);
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_addr = addr;
    bus.lut_wr_data = data;
    bus.lut_wr_abs  = abs_v;
  endtask

  task automatic test_reset();
    obs_t e, o;
    int   n = 0;
    cyc(0, 0, 0, 0, 0, 0, 4'd0, mk(12'h000, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, 4'd0, mk(12'h000, 0, 0));
    cyc(1, 0, 0, 0, 1, 0, 4'd7, mk(12'h000, 0, 0)); // IDLE ignores branch
    cyc(1, 1, 0, 0, 0, 0, 4'd0, mk(12'h000, 0, 0)); // start -> RUN at 0
    for (int i = 1; i <= 5; i++)
      cyc(1, 0, 0, 0, 0, 0, 4'd0, mk(D'(i), 0, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset step %0d: got pc=%h done=%b miss=%b, want pc=%h done=%b miss=%b",
                 n, o.pc, o.done, o.miss, e.pc, e.done, e.miss);
      end
      n++;
    end
  endtask

  task automatic test_imm_branch();
    obs_t e, o;
    int   n = 0;
    for (int i = 6; i <= 16; i++)
      cyc(1, 0, 0, 0, 0, 0, 4'd0, mk(D'(i), 0, 0));
    cyc(1, 0, 0, 0, 1, 0, 4'b1101, mk(12'h00D, 0, 0)); // 0x010 - 3
    cyc(1, 0, 0, 0, 1, 0, 4'b0111, mk(12'h014, 0, 0)); // 0x00D + 7
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL imm_branch step %0d: got pc=%h done=%b miss=%b, want pc=%h done=%b miss=%b",
                 n, o.pc, o.done, o.miss, e.pc, e.done, e.miss);
      end
      n++;
    end
  endtask

  task automatic test_lut_branch();
    obs_t e, o;
    int   n = 0;
    lut_wr(4'd0, 12'hF9B, 1'b0);
    cyc(1, 0, 0, 0, 0, 0, 4'd0, mk(12'h015, 0, 0));
    lut_wr(4'd13, 12'h200, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 4'd0, mk(12'h016, 0, 0));
    lut_wr(4'd15, 12'h070, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 4'd0, mk(12'h017, 0, 0));
    cyc(1, 0, 0, 0, 1, 1, 4'd15, mk(12'h070, 0, 0)); // absolute jump
    cyc(1, 0, 0, 0, 1, 1, 4'd0,  mk(12'h00B, 0, 0)); // 0x070 + (-0x65)
    cyc(1, 0, 0, 0, 1, 1, 4'd13, mk(12'h200, 0, 0)); // absolute 0x200
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL lut_branch step %0d: got pc=%h done=%b miss=%b, want pc=%h done=%b miss=%b",
                 n, o.pc, o.done, o.miss, e.pc, e.done, e.miss);
      end
      n++;
    end
  endtask

  task automatic test_lut_miss();
    obs_t e, o;
    int   n = 0;
    lut_wr(4'd15, 12'h030, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 4'd0, mk(12'h201, 0, 0));
    cyc(1, 0, 0, 0, 1, 1, 4'd15, mk(12'h030, 0, 0));
    cyc(1, 0, 0, 0, 1, 1, 4'd5,  mk(12'h031, 0, 1)); // unwritten entry
    cyc(1, 0, 0, 0, 0, 0, 4'd0,  mk(12'h032, 0, 0)); // pulse is one cycle
    lut_wr(4'd5, 12'h3AA, 1'b1);
    cyc(1, 0, 0, 0, 1, 1, 4'd5,  mk(12'h033, 0, 1)); // same-cycle write unseen
    cyc(1, 0, 0, 0, 1, 1, 4'd5,  mk(12'h3AA, 0, 0)); // now valid
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL lut_miss step %0d: got pc=%h done=%b miss=%b, want pc=%h done=%b miss=%b",
                 n, o.pc, o.done, o.miss, e.pc, e.done, e.miss);
      end
      n++;
    end
  endtask

  task automatic test_stall_halt();
    obs_t e, o;
    int   n = 0;
    cyc(1, 0, 0, 0, 1, 1, 4'd6, mk(12'h3AB, 0, 1)); // miss
    lut_wr(4'd2, 12'h0F0, 1'b1);                    // write during stall
    cyc(1, 0, 1, 1, 1, 0, 4'd7, mk(12'h3AB, 0, 0)); // stall wins, miss cleared
    cyc(1, 0, 0, 0, 1, 1, 4'd2, mk(12'h0F0, 0, 0)); // stalled write landed
    cyc(1, 0, 1, 0, 0, 0, 4'd0, mk(12'h0F0, 1, 0)); // halt
    cyc(1, 0, 0, 0, 1, 0, 4'd7, mk(12'h0F0, 1, 0)); // HALTED holds
    cyc(1, 1, 0, 0, 0, 0, 4'd0, mk(12'h000, 0, 0)); // restart
    cyc(1, 0, 0, 0, 0, 0, 4'd0, mk(12'h001, 0, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL stall_halt step %0d: got pc=%h done=%b miss=%b, want pc=%h done=%b miss=%b",
                 n, o.pc, o.done, o.miss, e.pc, e.done, e.miss);
      end
      n++;
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    int   n = 0;
    cyc(1, 0, 0, 0, 0, 0, 4'd0,    mk(12'h002, 0, 0));
    cyc(1, 0, 0, 0, 1, 0, 4'b1101, mk(12'hFFF, 0, 0)); // 0x002 - 3 wraps
    cyc(1, 0, 0, 0, 0, 0, 4'd0,    mk(12'h000, 0, 0)); // 0xFFF + 1 wraps
    cyc(1, 0, 0, 0, 0, 0, 4'd0,    mk(12'h001, 0, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL wrap step %0d: got pc=%h done=%b miss=%b, want pc=%h done=%b miss=%b",
                 n, o.pc, o.done, o.miss, e.pc, e.done, e.miss);
      end
      n++;
    end
  endtask

  task automatic test_mid_reset();
    obs_t e, o;
    int   n = 0;
    lut_wr(4'd15, 12'h123, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 4'd0,  mk(12'h002, 0, 0));
    cyc(1, 0, 0, 0, 1, 1, 4'd15, mk(12'h123, 0, 0));
    cyc(0, 1, 0, 0, 1, 1, 4'd15, mk(12'h000, 0, 0)); // reset overrides all
    cyc(1, 0, 0, 0, 1, 0, 4'd3,  mk(12'h000, 0, 0)); // back in IDLE
    cyc(1, 1, 0, 0, 0, 0, 4'd0,  mk(12'h000, 0, 0));
    cyc(1, 1, 0, 0, 0, 0, 4'd0,  mk(12'h001, 0, 0)); // start ignored in RUN
    cyc(1, 0, 0, 0, 1, 1, 4'd15, mk(12'h002, 0, 1)); // valid bits cleared
    cyc(1, 0, 0, 0, 1, 1, 4'd0,  mk(12'h003, 0, 1));
    cyc(1, 0, 0, 0, 0, 0, 4'd0,  mk(12'h004, 0, 0));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL mid_reset step %0d: got pc=%h done=%b miss=%b, want pc=%h done=%b miss=%b",
                 n, o.pc, o.done, o.miss, e.pc, e.done, e.miss);
      end
      n++;
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.halt        = 1'b0;
    bus.stall       = 1'b0;
    bus.branch_en   = 1'b0;
    bus.imm_or_lut  = 1'b0;
    bus.ctrl        = '0;
    bus.lut_wr_en   = 1'b0;
    bus.lut_wr_addr = '0;
    bus.lut_wr_data = '0;
    bus.lut_wr_abs  = 1'b0;
    @(posedge Clk);
    #1;
    test_reset();
    test_imm_branch();
    test_lut_branch();
    test_lut_miss();
    test_stall_halt();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter block: owns the PC register and computes branch targets from either a sign-extended immediate or a run-time-writable branch LUT.
- LUT entries are relative (signed offset) or absolute targets, selected per entry.
- Adds start/halt sequencing, stall, and a miss flag for unprogrammed LUT entries.
- Feeds the instruction-memory address; driven by the control decoder and ALU branch-condition output.

Parameters:
- D, 12, PC / target width in bits.
- IMM_W, 4, immediate/LUT-index field width; immediate is sign-extended to D.
- LUT_DEPTH, 16, number of LUT entries (≤ 2**IMM_W); LUT_AW = $clog2(LUT_DEPTH).
- START_ADDR, 0, PC value after reset and on every start.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  synchronous, active-low reset.
- start  in  1  begin/restart program execution.
- halt  in  1  stop execution (current instruction is the halt).
- stall  in  1  freeze PC and state for this cycle.
- branch_en  in  1  branch taken this cycle.
- imm_or_lut  in  1  1 = target from LUT, 0 = PC-relative immediate.
- ctrl  in  IMM_W  immediate value or LUT index.
- lut_wr_en  in  1  LUT write strobe.
- lut_wr_addr  in  LUT_AW  LUT write index.
- lut_wr_data  in  D  offset (signed) or absolute target.
- lut_wr_abs  in  1  written entry is absolute.
- prog_counter  out  D  current PC.
- done  out  1  high while in HALTED.
- lut_miss  out  1  one-cycle pulse: branch through an invalid LUT entry.

Behaviour:
- Reset (Reset==0 at edge): prog_counter=START_ADDR, done=0, lut_miss=0, state=IDLE, all LUT valid bits cleared. Entry data need not be cleared. Reset overrides every other input, including a mid-run reset.
- States: IDLE, RUN, HALTED.
- IDLE: PC holds START_ADDR. start=1 → RUN next cycle with PC=START_ADDR. All other control inputs ignored.
- RUN, per cycle, priority order:
  - stall=1: PC, state and lut_miss all hold/clear (lut_miss=0). halt and branch_en are ignored.
  - halt=1: → HALTED, PC holds, done=1 next cycle.
  - branch_en=1, imm_or_lut=0: PC <= PC + sext(ctrl).
  - branch_en=1, imm_or_lut=1, index < LUT_DEPTH and entry valid:
    - abs entry: PC <= entry.
    - relative entry: PC <= PC + entry.
  - branch_en=1, imm_or_lut=1, index ≥ LUT_DEPTH or entry invalid: PC <= PC+1; lut_miss=1 for one cycle.
  - otherwise: PC <= PC+1.
- start while in RUN is ignored.
- HALTED: done=1, PC holds. start=1 → RUN, PC=START_ADDR, done=0 next cycle.
- Arithmetic: all additions are modulo 2**D; wrap-around is silent (0xFFF+1 → 0x000 for D=12; PC 0x002 + (-3) → 0xFFF).
- LUT write:
  - Accepted in any state, including during stall.
  - Sets the entry's valid bit, data and abs flag; visible from the next cycle.
  - A same-cycle read of the index being written uses the old contents/valid bit.
  - lut_wr_addr ≥ LUT_DEPTH: write is dropped.
- Latency: PC update is one cycle after the inputs are sampled. prog_counter is a direct register output; no combinational path from inputs to prog_counter.

Test Plan:
- Reset low 2 cycles, then start=1 → PC=0 in RUN; 5 idle cycles → PC 1,2,3,4,5; done=0.
- PC=0x010, branch_en=1, imm_or_lut=0, ctrl=4'b1101 (-3) → PC=0x00D; ctrl=4'b0111 → PC=0x014.
- Write LUT[0]=0xF9B relative and LUT[13]=0x200 absolute, then branch via ctrl=0 from PC=0x070 → PC=0x00B; ctrl=13 → PC=0x200.
- Branch via an unwritten entry ctrl=5 from PC=0x030 → PC=0x031, lut_miss high exactly 1 cycle. Write LUT[5] and branch through it in the same cycle → old (invalid) value used, miss reported.
- stall=1 with halt=1 and branch_en=1 → PC and state unchanged. Release stall, halt=1 → done=1, PC frozen. start=1 → PC=START_ADDR, done=0.
- PC=0xFFF, no branch → PC=0x000. Reset low mid-run at PC=0x123 → PC=START_ADDR, IDLE, LUT branches miss afterwards.
